// File: rtl/mem_access_unit_if.sv
// Byte-serial request/acknowledge bus between the MEM-stage initiator and the
// byte-wide data memory array.
interface mem_access_unit_if #(
    parameter int AW = 6
) ();
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic          mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: turns lw/lb/lh/sw/sb/sh into big-endian byte transfers
// on a req/ack port and stalls the pipeline until the access completes.
module mem_access_unit #(
    parameter int AW       = 6,
    parameter bit SIGN_EXT = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [31:0]               address,
    input  logic [1:0]                memread,
    input  logic [1:0]                memwrite,
    input  logic [31:0]               writedata,
    output logic [31:0]               read_data,
    output logic                      stall,
    output logic                      done,
    output logic                      error,
    mem_access_unit_if.master         mem
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_WORD = 2'b01;
    localparam logic [1:0] OP_BYTE = 2'b10;
    localparam logic [1:0] OP_HALF = 2'b11;

    logic [1:0]    state;
    logic [AW-1:0] base;
    logic [31:0]   wdata_q;
    logic          is_store;
    logic [1:0]    size_q;
    logic [2:0]    count;
    logic [1:0]    idx;
    logic [23:0]   asm_q;

    logic          start;
    logic          conflict;
    logic          misaligned;
    logic [1:0]    op;
    logic [2:0]    req_count;
    logic          last_byte;
    logic [2:0]    byte_sel;
    logic [31:0]   shifted;
    logic [31:0]   load_value;
    logic          unused_addr;

    assign unused_addr = ^address[31:AW];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        op         = (memread != 2'b00) ? memread : memwrite;
        start      = (memread != 2'b00) || (memwrite != 2'b00);
        conflict   = (memread != 2'b00) && (memwrite != 2'b00);
        misaligned = ((op == OP_WORD) && (address[1:0] != 2'b00)) ||
                     ((op == OP_HALF) && address[0]);
        case (op)
            OP_WORD: req_count = 3'd4;
            OP_BYTE: req_count = 3'd1;
            default: req_count = 3'd2;
        endcase

        last_byte = ({1'b0, idx} == (count - 3'd1));
        byte_sel  = count - 3'd1 - {1'b0, idx};
        shifted   = {asm_q, mem.mem_rdata};

        // Value committed on the final ack; extension uses the freshly shifted bits.
        case (size_q)
            OP_WORD: load_value = shifted;
            OP_BYTE: load_value = {{24{SIGN_EXT && shifted[7]}}, shifted[7:0]};
            OP_HALF: load_value = {{16{SIGN_EXT && shifted[15]}}, shifted[15:0]};
            default: load_value = 32'd0;
        endcase

        mem.mem_req   = (state == S_XFER);
        mem.mem_we    = (state == S_XFER) && is_store;
        mem.mem_addr  = base + AW'(idx);
        mem.mem_wdata = ((state == S_XFER) && is_store) ?
                        8'(wdata_q >> {byte_sel, 3'b000}) : 8'd0;

        stall = ((state == S_IDLE) && start) || (state == S_XFER);
        done  = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state     <= S_IDLE;
            base      <= '0;
            wdata_q   <= 32'd0;
            is_store  <= 1'b0;
            size_q    <= 2'b00;
            count     <= 3'd0;
            idx       <= 2'd0;
            asm_q     <= 24'd0;
            read_data <= 32'd0;
            error     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base     <= address[AW-1:0];
                        wdata_q  <= writedata;
                        is_store <= (memwrite != 2'b00);
                        size_q   <= op;
                        count    <= req_count;
                        idx      <= 2'd0;
                        asm_q    <= 24'd0;
                        error    <= conflict || misaligned;
                        if (conflict || misaligned) begin
                            read_data <= 32'd0;
                            state     <= S_DONE;
                        end else begin
                            state <= S_XFER;
                        end
                    end
                end
                S_XFER: begin
                    if (mem.mem_ack) begin
                        if (!is_store) begin
                            asm_q <= shifted[23:0];
                        end
                        if (last_byte) begin
                            state <= S_DONE;
                            if (!is_store) begin
                                read_data <= load_value;
                            end
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: byte memory responder plus a
// word-level reference model of loads, stores, alignment and latency.
module tb_mem_access_unit;

    localparam int AW       = 6;
    localparam int MEM_SIZE = 1 << AW;
    localparam bit SIGN_EXT = 1'b1;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [1:0]  memread;
    logic [1:0]  memwrite;
    logic [31:0] writedata;
    logic [31:0] read_data;
    logic        stall;
    logic        done;
    logic        error;

    mem_access_unit_if #(.AW(AW)) mem_if ();

    mem_access_unit #(.AW(AW), .SIGN_EXT(SIGN_EXT)) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .memread   (memread),
        .memwrite  (memwrite),
        .writedata (writedata),
        .read_data (read_data),
        .stall     (stall),
        .done      (done),
        .error     (error),
        .mem       (mem_if)
    );

    always #5 clk = ~clk;

    logic [7:0]  model_mem [0:MEM_SIZE-1];
    logic [31:0] last_read;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int op_count(input logic [1:0] code);
        case (code)
            2'b01:   return 4;
            2'b10:   return 1;
            default: return 2;
        endcase
    endfunction

    function automatic int wrap(input int a);
        return a % MEM_SIZE;
    endfunction

    // Big-endian load of 1/2/4 bytes from the model memory, then extension.
    function automatic logic [31:0] load_expect(input logic [1:0] code, input int a);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < op_count(code); i++)
            v = (v << 8) | 32'(model_mem[wrap(a + i)]);
        if (SIGN_EXT && code == 2'b10 && v[7])  v = v | 32'hFFFF_FF00;
        if (SIGN_EXT && code == 2'b11 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic go_idle(input int cycles);
        @(negedge clk);
        memread  = 2'b00;
        memwrite = 2'b00;
        for (int i = 0; i < cycles; i++) begin
            #1;
            check("idle_stall", stall, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic do_op(input logic [1:0] rd, input logic [1:0] wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int first_wait, input int max_wait,
                         input int abort_after);
        logic [1:0]  code;
        logic        err_exp;
        logic        store;
        int          cnt;
        int          base;
        logic [31:0] exp_rd;
        logic [7:0]  exp_bytes [4];
        logic [7:0]  pre_bytes [4];
        int          n_ack;
        int          stall_cnt;
        int          waits;
        int          total_waits;
        logic        held;
        logic [31:0] prev;
        logic        done_seen;
        logic        aborted;

        code    = (rd != 2'b00) ? rd : wr;
        store   = (rd == 2'b00) && (wr != 2'b00);
        cnt     = op_count(code);
        base    = int'(addr[AW-1:0]);
        err_exp = ((rd != 2'b00) && (wr != 2'b00)) ||
                  (code == 2'b01 && addr[1:0] != 2'b00) ||
                  (code == 2'b11 && addr[0]);
        exp_rd  = err_exp ? 32'd0 : (store ? last_read : load_expect(code, base));
        for (int i = 0; i < 4; i++) begin
            exp_bytes[i] = 8'(wdata >> (8 * (cnt - 1 - i)));
            pre_bytes[i] = model_mem[wrap(base + i)];
        end

        n_ack = 0; stall_cnt = 0; total_waits = 0; held = 1'b0; prev = 32'd0;
        done_seen = 1'b0; aborted = 1'b0; waits = first_wait;

        @(negedge clk);
        memread   = rd;
        memwrite  = wr;
        address   = addr;
        writedata = wdata;

        for (int cyc = 0; cyc < 80; cyc++) begin
            #1;
            if (cyc == 0) check("done_pulse", done, 1'b0);
            if (done) begin
                done_seen = 1'b1;
                break;
            end
            if (stall) stall_cnt++;
            if (mem_if.mem_req) begin
                if (held)
                    check("hold", {mem_if.mem_addr, mem_if.mem_we, mem_if.mem_wdata}, prev);
                if (abort_after != 0 && n_ack == abort_after) begin
                    aborted = 1'b1;
                    break;
                end
                mem_if.mem_rdata = model_mem[mem_if.mem_addr];
                if (waits > 0) begin
                    mem_if.mem_ack = 1'b0;
                    waits--;
                    total_waits++;
                    held = 1'b1;
                    prev = 32'({mem_if.mem_addr, mem_if.mem_we, mem_if.mem_wdata});
                end else begin
                    mem_if.mem_ack = 1'b1;
                    held = 1'b0;
                    check("addr", mem_if.mem_addr, wrap(base + n_ack));
                    check("we", mem_if.mem_we, store);
                    if (mem_if.mem_we) model_mem[mem_if.mem_addr] = mem_if.mem_wdata;
                    n_ack++;
                    waits = $urandom_range(0, max_wait);
                end
            end else begin
                mem_if.mem_ack = 1'($urandom_range(0, 1));
                held = 1'b0;
            end
            @(negedge clk);
        end

        if (aborted) begin
            reset          = 1'b1;
            mem_if.mem_ack = 1'b0;
            memread        = 2'b00;
            memwrite       = 2'b00;
            @(negedge clk);
            reset = 1'b0;
            #1;
            check("rst_req", mem_if.mem_req, 1'b0);
            check("rst_stall", stall, 1'b0);
            check("rst_done", done, 1'b0);
            check("rst_addr", mem_if.mem_addr, 0);
            check("rst_rdata", read_data, 32'd0);
            last_read = 32'd0;
            for (int i = 0; i < cnt; i++)
                check("rst_mem", model_mem[wrap(base + i)],
                      (i < abort_after) ? exp_bytes[i] : pre_bytes[i]);
            return;
        end

        check("done_seen", done_seen, 1'b1);
        if (!done_seen) return;
        check("stall_cycles", stall_cnt, err_exp ? 1 : 1 + cnt + total_waits);
        check("error", error, err_exp);
        check("read_data", read_data, exp_rd);
        check("byte_count", n_ack, err_exp ? 0 : cnt);
        check("done_req", mem_if.mem_req, 1'b0);
        check("done_stall", stall, 1'b0);
        if (store && !err_exp)
            for (int i = 0; i < cnt; i++)
                check("store_byte", model_mem[wrap(base + i)], exp_bytes[i]);
        last_read = exp_rd;
    endtask

    initial begin
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic [31:0] a;
        int          kind;

        for (int i = 0; i < MEM_SIZE; i++) model_mem[i] = 8'($urandom);
        reset = 1'b1; address = 32'd0; memread = 2'b00; memwrite = 2'b00; writedata = 32'd0;
        mem_if.mem_ack = 1'b0; mem_if.mem_rdata = 8'd0; last_read = 32'd0;

        repeat (2) @(negedge clk);
        #1;
        check("reset_rdata", read_data, 32'd0);
        check("reset_done", done, 1'b0);
        check("reset_error", error, 1'b0);
        check("reset_req", mem_if.mem_req, 1'b0);
        check("reset_we", mem_if.mem_we, 1'b0);
        check("reset_addr", mem_if.mem_addr, 0);
        check("reset_wdata", mem_if.mem_wdata, 8'd0);
        check("reset_stall", stall, 1'b0);
        reset = 1'b0;
        go_idle(2);

        model_mem[8] = 8'h11; model_mem[9] = 8'h22; model_mem[10] = 8'h33; model_mem[11] = 8'h44;
        do_op(2'b01, 2'b00, 32'h08, 32'h0, 0, 0, 0);
        check("lw_value", read_data, 32'h1122_3344);

        do_op(2'b00, 2'b11, 32'h0A, 32'hDEAD_BEEF, 2, 0, 0);
        check("sh_byte0", model_mem[10], 8'hBE);
        check("sh_byte1", model_mem[11], 8'hEF);

        model_mem[5] = 8'h80;
        do_op(2'b10, 2'b00, 32'h05, 32'h0, 0, 0, 0);
        check("lb_value", read_data, SIGN_EXT ? 32'hFFFF_FF80 : 32'h0000_0080);
        model_mem[4] = 8'h7F; model_mem[5] = 8'hFF;
        do_op(2'b11, 2'b00, 32'h04, 32'h0, 0, 1, 0);
        check("lh_value", read_data, 32'h0000_7FFF);

        do_op(2'b01, 2'b00, 32'h06, 32'h0, 0, 0, 0);
        do_op(2'b01, 2'b01, 32'h10, 32'h1234_5678, 0, 0, 0);
        do_op(2'b11, 2'b00, 32'h21, 32'h0, 0, 0, 0);

        do_op(2'b00, 2'b01, 32'h00, 32'hCAFE_F00D, 0, 0, 0);
        do_op(2'b01, 2'b00, 32'h00, 32'h0, 0, 0, 0);
        check("b2b_value", read_data, 32'hCAFE_F00D);

        do_op(2'b01, 2'b00, 32'h0000_0140, 32'h0, 0, 1, 0);
        do_op(2'b00, 2'b10, 32'h3F, 32'h0000_00A5, 1, 0, 0);
        go_idle(1);

        do_op(2'b00, 2'b01, 32'h3C, 32'h0102_0304, 0, 0, 2);
        go_idle(1);
        do_op(2'b01, 2'b00, 32'h3C, 32'h0, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            rd = 2'b00; wr = 2'b00;
            if (kind == 0) begin
                rd = 2'($urandom_range(1, 3));
                wr = 2'($urandom_range(1, 3));
            end else if (kind < 5) begin
                rd = 2'($urandom_range(1, 3));
            end else begin
                wr = 2'($urandom_range(1, 3));
            end
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if ((rd | wr) == 2'b01) a[1:0] = 2'b00;
                if ((rd | wr) == 2'b11) a[0]   = 1'b0;
            end
            do_op(rd, wr, a, $urandom, $urandom_range(0, 2), 2, 0);
            if ($urandom_range(0, 3) == 0) go_idle(1);
        end

        go_idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
